mem_bus_sequencer: RTL and testbench
====================================

Name: mem_bus_sequencer

Overview:
Registered sequencer and arbiter for the single shared memory bus (addr_data[9:0], read_write, write_commit). Three requesters share the bus: instruction fetch, execute-stage load, and commit-stage store. The block also owns the halt signalling. Each transfer is sequenced through an FSM with fixed bus timing, and a starvation counter stops data traffic from locking out fetch.

Parameters:
ADDR_W, 10, memory address / bus width
INSTR_W, 12, width of mem_result and returned read data
ST_DATA_W, 6, store payload width
MAX_DATA_BURST, 4, max consecutive load/store grants while fetch waits (range 1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
fetch_req  in  1  fetch request; held until fetch_gnt
fetch_addr  in  ADDR_W  fetch address (pc)
fetch_gnt  out  1  fetch accepted this cycle
fetch_valid  out  1  one-cycle pulse: fetch_data valid
fetch_data  out  INSTR_W  registered fetched word
ld_req  in  1  load request; held until ld_gnt
ld_addr  in  ADDR_W  load address
ld_gnt  out  1  load accepted this cycle
ld_valid  out  1  one-cycle pulse: ld_data valid
ld_data  out  INSTR_W  registered load word
st_req  in  1  store request; held until st_gnt
st_addr  in  ADDR_W  store address
st_data  in  ST_DATA_W  store payload
st_upper  in  1  STOREU flag (bus bit 6)
st_gnt  out  1  store accepted this cycle
st_done  out  1  one-cycle pulse: store complete
halt_req  in  1  HALT reached commit
halted  out  1  sticky halted status
mem_result  in  INSTR_W  memory read data, valid in same cycle as driven address
mem_bus_out  out  ADDR_W  drives addr_data[9:0]
mem_read_write  out  1  1 = read, 0 = write
write_commit  out  1  store data phase / halt marker

Behaviour:
- Reset (sync, rst=1): state IDLE; mem_bus_out=0, mem_read_write=1, write_commit=0; all gnt/valid/done=0; fetch_data=ld_data=0; streak=0; halted=0. rst during any transfer aborts it. No valid or done pulse is produced for the aborted transfer, and write_commit is 0 the next cycle.
- States: IDLE, FETCH, LOAD, ST_ADDR, ST_DATA, HALT. Bus outputs are registered and are a function of state plus captured registers only.
  - IDLE: bus=0, rw=1, wc=0.
  - FETCH / LOAD: bus=captured addr, rw=1, wc=0.
  - ST_ADDR: bus=addr, rw=0, wc=0.
  - ST_DATA: bus={0, st_upper, st_data} (bits 9:7 = 0), rw=0, wc=1.
  - HALT: bus=0, rw=1, wc=1.
- Arbitration point: IDLE, FETCH, LOAD, ST_DATA. This allows back-to-back transfers with no idle cycle. ST_ADDR and HALT never grant.
- Grant (combinational, at an arbitration point):
  - If streak==MAX_DATA_BURST and fetch_req, fetch wins.
  - Otherwise the priority order is st_req > ld_req > fetch_req > halt_req.
  - Exactly one gnt per cycle. The winner's addr/data are captured, and the next state is that transfer's first state.
  - With no request, the next state is IDLE.
- Halt: granted only when no other req is present. It enters HALT, which is terminal until rst; halted=1 from HALT entry. rw=1 with wc=1 occurs only in HALT.
- Latency (gnt in cycle N):
  - Fetch/load: bus driven N+1. mem_result is sampled at the end of N+1. fetch_valid/ld_valid and data appear in N+2.
  - Store: address phase N+1, data phase N+2, st_done in N+3.
- Streak counter, updated at each grant:
  - Increments on an ld/st grant while fetch_req=1.
  - Clears on a fetch grant, or in any cycle with fetch_req=0.
  - Saturates at MAX_DATA_BURST.
- Requester dropping req before gnt: legal, no effect. Req held after gnt is treated as a new request.
- fetch_data/ld_data hold their value until the next capture.

Decomposition:
- common_def package gains:
  - enum mem_seq_state_e (IDLE, FETCH, LOAD, ST_ADDR, ST_DATA, HALT)
  - constants MEM_RD=1'b1, MEM_WR=1'b0, STORE_UPPER_BIT=6
  - reuse of the existing HALT opcode constant for requesters
- One sub-module: bus_fair_arbiter. It holds the priority logic and streak counter, and outputs a one-hot grant vector.

Test Plan:
1. Fetch only: fetch_req, addr 0x005, mem_result=0xA3C in cycle 1 -> fetch_gnt c0; bus=0x005 rw=1 wc=0 c1; fetch_valid=1 with fetch_data=0xA3C c2. A second fetch 0x006 held is granted c1 and drives the bus c2.
2. Store: st_addr=0x3F0, st_data=0x2A, st_upper=1 -> bus 0x3F0 rw=0 wc=0 c1; bus 0x06A rw=0 wc=1 c2; st_done c3.
3. st, ld, fetch raised together and held -> grant order st, ld, fetch. No cycle has more than one gnt, and no bus cycle is idle between transfers.
4. Starvation, MAX_DATA_BURST=4: ld_req and fetch_req held continuously -> 4 ld grants, then a fetch grant, then streak=0 and loads resume.
5. halt_req with fetch_req pending -> fetch completes first, then HALT: bus=0 rw=1 wc=1 and halted=1 held for 20 cycles with no gnts. rst -> IDLE outputs the next cycle.
6. rst asserted in ST_ADDR -> next cycle IDLE values, write_commit never 1, no st_done.

Source files
------------

// File: rtl/common_def.sv
// Shared definitions for the memory bus sequencer and its requesters.
package common_def;

   // Sequencer states: one state per bus phase, plus the terminal halt state.
   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      LOAD,
      ST_ADDR,
      ST_DATA,
      HALT
   } mem_seq_state_e;

   // Bus direction encoding on mem_read_write.
   localparam logic MEM_RD = 1'b1;
   localparam logic MEM_WR = 1'b0;

   // Bit of the store data word that carries the STOREU flag.
   localparam int STORE_UPPER_BIT = 6;

   // HALT opcode; the commit stage raises halt_req when it retires this opcode.
   localparam logic [3:0] OP_HALT = 4'hF;

   // One-hot grant vector layout shared by the arbiter and the sequencer.
   localparam int GNT_W     = 4;
   localparam int GNT_ST    = 0;
   localparam int GNT_LD    = 1;
   localparam int GNT_FETCH = 2;
   localparam int GNT_HALT  = 3;

endpackage

// File: rtl/bus_fair_arbiter.sv
// Fixed-priority bus arbiter with a starvation guard that forces a fetch grant
// after MAX_DATA_BURST consecutive data grants while fetch is waiting.
module bus_fair_arbiter
   import common_def::*;
#(
   parameter int MAX_DATA_BURST = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             arb_en,
   input  logic             fetch_req,
   input  logic             ld_req,
   input  logic             st_req,
   input  logic             halt_req,
   output logic [GNT_W-1:0] gnt
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_BURST);

   logic [3:0] streak;

   // Pick exactly one winner: starved fetch first, then st > ld > fetch > halt.
   // NOTE: every output of an always_comb gets a default on entry so that no
   // path leaves it unassigned; otherwise synthesis infers a latch.
   always_comb begin
      gnt = '0;
      if (arb_en) begin
         if (fetch_req && streak == STREAK_MAX) gnt[GNT_FETCH] = 1'b1;
         else if (st_req)                       gnt[GNT_ST]    = 1'b1;
         else if (ld_req)                       gnt[GNT_LD]    = 1'b1;
         else if (fetch_req)                    gnt[GNT_FETCH] = 1'b1;
         else if (halt_req)                     gnt[GNT_HALT]  = 1'b1;
      end
   end

   // Count data grants won while fetch waits; saturate, clear when fetch is served or idle.
   // NOTE: clocked state uses non-blocking assignments so every flop samples the
   // pre-edge values; blocking here would create order-dependent simulation.
   always_ff @(posedge clk) begin
      if (rst) begin
         streak <= '0;
      end else if (!fetch_req || gnt[GNT_FETCH]) begin
         streak <= '0;
      end else if ((gnt[GNT_LD] || gnt[GNT_ST]) && streak != STREAK_MAX) begin
         streak <= streak + 4'd1;
      end
   end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Sequencer for the shared memory bus: arbitrates fetch, load, store and halt,
// drives registered bus phases and returns read data one cycle after the bus.
module mem_bus_sequencer
   import common_def::*;
#(
   parameter int ADDR_W         = 10,
   parameter int INSTR_W        = 12,
   parameter int ST_DATA_W      = 6,
   parameter int MAX_DATA_BURST = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 fetch_req,
   input  logic [ADDR_W-1:0]    fetch_addr,
   output logic                 fetch_gnt,
   output logic                 fetch_valid,
   output logic [INSTR_W-1:0]   fetch_data,
   input  logic                 ld_req,
   input  logic [ADDR_W-1:0]    ld_addr,
   output logic                 ld_gnt,
   output logic                 ld_valid,
   output logic [INSTR_W-1:0]   ld_data,
   input  logic                 st_req,
   input  logic [ADDR_W-1:0]    st_addr,
   input  logic [ST_DATA_W-1:0] st_data,
   input  logic                 st_upper,
   output logic                 st_gnt,
   output logic                 st_done,
   input  logic                 halt_req,
   output logic                 halted,
   input  logic [INSTR_W-1:0]   mem_result,
   output logic [ADDR_W-1:0]    mem_bus_out,
   output logic                 mem_read_write,
   output logic                 write_commit
);

   mem_seq_state_e       state, state_next;
   logic                 arb_en;
   logic [GNT_W-1:0]     gnt;
   logic [ADDR_W-1:0]    cap_addr, cap_addr_next;
   logic [ST_DATA_W-1:0] cap_st_data, cap_st_data_next;
   logic                 cap_upper, cap_upper_next;
   logic [ADDR_W-1:0]    bus_next;
   logic                 rw_next, wc_next;

   // Store data phase word: payload in the low bits, STOREU flag at its bit, rest zero.
   function automatic logic [ADDR_W-1:0] store_word(input logic [ST_DATA_W-1:0] data,
                                                    input logic                 upper);
      logic [ADDR_W-1:0] word;
      word                  = '0;
      word[ST_DATA_W-1:0]   = data;
      word[STORE_UPPER_BIT] = upper;
      return word;
   endfunction

   // Grants are only offered in states that end a bus phase, and never during reset.
   assign arb_en = !rst && (state inside {IDLE, FETCH, LOAD, ST_DATA});

   bus_fair_arbiter #(
      .MAX_DATA_BURST(MAX_DATA_BURST)
   ) u_arbiter (
      .clk      (clk),
      .rst      (rst),
      .arb_en   (arb_en),
      .fetch_req(fetch_req),
      .ld_req   (ld_req),
      .st_req   (st_req),
      .halt_req (halt_req),
      .gnt      (gnt)
   );

   assign fetch_gnt = gnt[GNT_FETCH];
   assign ld_gnt    = gnt[GNT_LD];
   assign st_gnt    = gnt[GNT_ST];

   // Next state, winner capture, and the bus pattern for the state being entered.
   always_comb begin
      state_next       = state;
      cap_addr_next    = cap_addr;
      cap_st_data_next = cap_st_data;
      cap_upper_next   = cap_upper;
      case (state)
         ST_ADDR: state_next = ST_DATA;
         HALT:    state_next = HALT;
         default: begin
            state_next = IDLE;
            if (gnt[GNT_ST]) begin
               state_next       = ST_ADDR;
               cap_addr_next    = st_addr;
               cap_st_data_next = st_data;
               cap_upper_next   = st_upper;
            end else if (gnt[GNT_LD]) begin
               state_next    = LOAD;
               cap_addr_next = ld_addr;
            end else if (gnt[GNT_FETCH]) begin
               state_next    = FETCH;
               cap_addr_next = fetch_addr;
            end else if (gnt[GNT_HALT]) begin
               state_next = HALT;
            end
         end
      endcase

      bus_next = '0;
      rw_next  = MEM_RD;
      wc_next  = 1'b0;
      case (state_next)
         FETCH, LOAD: bus_next = cap_addr_next;
         ST_ADDR: begin
            bus_next = cap_addr_next;
            rw_next  = MEM_WR;
         end
         ST_DATA: begin
            bus_next = store_word(cap_st_data_next, cap_upper_next);
            rw_next  = MEM_WR;
            wc_next  = 1'b1;
         end
         HALT:    wc_next = 1'b1;
         default: ;
      endcase
   end

   // State, captured request fields and registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         cap_addr       <= '0;
         cap_st_data    <= '0;
         cap_upper      <= 1'b0;
         mem_bus_out    <= '0;
         mem_read_write <= MEM_RD;
         write_commit   <= 1'b0;
         halted         <= 1'b0;
      end else begin
         state          <= state_next;
         cap_addr       <= cap_addr_next;
         cap_st_data    <= cap_st_data_next;
         cap_upper      <= cap_upper_next;
         mem_bus_out    <= bus_next;
         mem_read_write <= rw_next;
         write_commit   <= wc_next;
         halted         <= (state_next == HALT);
      end
   end

   // Read data returns and completion pulses, one cycle after the bus phase.
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_valid <= 1'b0;
         fetch_data  <= '0;
         ld_valid    <= 1'b0;
         ld_data     <= '0;
         st_done     <= 1'b0;
      end else begin
         fetch_valid <= (state == FETCH);
         ld_valid    <= (state == LOAD);
         st_done     <= (state == ST_DATA);
         if (state == FETCH) fetch_data <= mem_result;
         if (state == LOAD)  ld_data    <= mem_result;
      end
   end

endmodule

// File: tb/tb_mem_bus_sequencer.sv
// Directed bench for mem_bus_sequencer: a per-cycle vector table for the basic
// fetch/store/load flows, then hand sequences for arbitration, starvation,
// halt and reset-abort.
module tb_mem_bus_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req, ld_req, st_req, st_upper, halt_req;
   logic [9:0]  fetch_addr, ld_addr, st_addr;
   logic [5:0]  st_data;
   logic [11:0] mem_result;
   logic        fetch_gnt, fetch_valid, ld_gnt, ld_valid, st_gnt, st_done, halted;
   logic [11:0] fetch_data, ld_data;
   logic [9:0]  mem_bus_out;
   logic        mem_read_write, write_commit;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct packed {
      logic        rst;
      logic        fr;
      logic [9:0]  fa;
      logic        lr;
      logic [9:0]  la;
      logic        sr;
      logic [9:0]  sa;
      logic [5:0]  sd;
      logic        su;
      logic        hr;
      logic [11:0] mr;
   } in_t;

   typedef struct packed {
      logic [2:0]  gnt;   // {st, ld, fetch}
      logic [9:0]  bus;
      logic        rw;
      logic        wc;
      logic        fv;
      logic [11:0] fd;
      logic        lv;
      logic [11:0] ld;
      logic        sdone;
      logic        halted;
   } out_t;

   typedef struct packed {
      in_t  in;
      out_t exp;
   } vec_t;

   localparam int NVEC = 13;
   vec_t vecs [NVEC];

   mem_bus_sequencer dut (
      .clk           (clk),
      .rst           (rst),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .fetch_gnt     (fetch_gnt),
      .fetch_valid   (fetch_valid),
      .fetch_data    (fetch_data),
      .ld_req        (ld_req),
      .ld_addr       (ld_addr),
      .ld_gnt        (ld_gnt),
      .ld_valid      (ld_valid),
      .ld_data       (ld_data),
      .st_req        (st_req),
      .st_addr       (st_addr),
      .st_data       (st_data),
      .st_upper      (st_upper),
      .st_gnt        (st_gnt),
      .st_done       (st_done),
      .halt_req      (halt_req),
      .halted        (halted),
      .mem_result    (mem_result),
      .mem_bus_out   (mem_bus_out),
      .mem_read_write(mem_read_write),
      .write_commit  (write_commit)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic mid();
      @(negedge clk);
   endtask

   task automatic apply(input in_t v);
      rst        = v.rst;
      fetch_req  = v.fr;
      fetch_addr = v.fa;
      ld_req     = v.lr;
      ld_addr    = v.la;
      st_req     = v.sr;
      st_addr    = v.sa;
      st_data    = v.sd;
      st_upper   = v.su;
      halt_req   = v.hr;
      mem_result = v.mr;
   endtask

   task automatic do_reset();
      apply('0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   function automatic out_t snap();
      out_t o;
      o.gnt    = {st_gnt, ld_gnt, fetch_gnt};
      o.bus    = mem_bus_out;
      o.rw     = mem_read_write;
      o.wc     = write_commit;
      o.fv     = fetch_valid;
      o.fd     = fetch_data;
      o.lv     = ld_valid;
      o.ld     = ld_data;
      o.sdone  = st_done;
      o.halted = halted;
      return o;
   endfunction

   initial begin
      //          rst   fr    fa      lr    la      sr    sa      sd    su    hr    mr
      vecs[0].in  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h000};
      vecs[1].in  = '{1'b0, 1'b1, 10'h005, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h000};
      vecs[2].in  = '{1'b0, 1'b1, 10'h006, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'hA3C};
      vecs[3].in  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'hBBB};
      vecs[4].in  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h000};
      vecs[5].in  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h3F0, 6'h2A, 1'b1, 1'b0, 12'h000};
      vecs[6].in  = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h123, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h000};
      vecs[7].in  = '{1'b0, 1'b0, 10'h000, 1'b1, 10'h123, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h000};
      vecs[8].in  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h5C7};
      vecs[9].in  = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h000};
      vecs[10].in = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h000};
      vecs[11].in = '{1'b1, 1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 10'h155, 6'h11, 1'b0, 1'b0, 12'h000};
      vecs[12].in = '{1'b0, 1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 10'h000, 6'h00, 1'b0, 1'b0, 12'h000};
      //           gnt     bus      rw    wc    fv    fd       lv    ld       sdone halted
      vecs[0].exp  = '{3'b000, 10'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0};
      vecs[1].exp  = '{3'b001, 10'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0};
      vecs[2].exp  = '{3'b001, 10'h005, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0};
      vecs[3].exp  = '{3'b000, 10'h006, 1'b1, 1'b0, 1'b1, 12'hA3C, 1'b0, 12'h000, 1'b0, 1'b0};
      vecs[4].exp  = '{3'b000, 10'h000, 1'b1, 1'b0, 1'b1, 12'hBBB, 1'b0, 12'h000, 1'b0, 1'b0};
      vecs[5].exp  = '{3'b100, 10'h000, 1'b1, 1'b0, 1'b0, 12'hBBB, 1'b0, 12'h000, 1'b0, 1'b0};
      vecs[6].exp  = '{3'b000, 10'h3F0, 1'b0, 1'b0, 1'b0, 12'hBBB, 1'b0, 12'h000, 1'b0, 1'b0};
      vecs[7].exp  = '{3'b010, 10'h06A, 1'b0, 1'b1, 1'b0, 12'hBBB, 1'b0, 12'h000, 1'b0, 1'b0};
      vecs[8].exp  = '{3'b000, 10'h123, 1'b1, 1'b0, 1'b0, 12'hBBB, 1'b0, 12'h000, 1'b1, 1'b0};
      vecs[9].exp  = '{3'b000, 10'h000, 1'b1, 1'b0, 1'b0, 12'hBBB, 1'b1, 12'h5C7, 1'b0, 1'b0};
      vecs[10].exp = '{3'b000, 10'h000, 1'b1, 1'b0, 1'b0, 12'hBBB, 1'b0, 12'h5C7, 1'b0, 1'b0};
      vecs[11].exp = '{3'b000, 10'h000, 1'b1, 1'b0, 1'b0, 12'hBBB, 1'b0, 12'h5C7, 1'b0, 1'b0};
      vecs[12].exp = '{3'b000, 10'h000, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0};

      // Table: reset state, fetch pair, store with STOREU, ST_ADDR not granting, load, reset.
      do_reset();
      for (int i = 0; i < NVEC; i++) begin
         apply(vecs[i].in);
         mid();
         check($sformatf("vec%0d", i), 64'(snap()), 64'(vecs[i].exp));
         tick();
      end

      // All three data/fetch requesters together: st, then ld, then fetch, no idle bus cycle.
      do_reset();
      fetch_req = 1'b1; fetch_addr = 10'h101;
      ld_req    = 1'b1; ld_addr    = 10'h202;
      st_req    = 1'b1; st_addr    = 10'h303; st_data = 6'h3F; st_upper = 1'b0;
      mid(); check("arb_c0_gnt", 64'({st_gnt, ld_gnt, fetch_gnt}), 64'(3'b100));
      tick(); st_req = 1'b0;
      mid(); check("arb_c1", 64'({st_gnt, ld_gnt, fetch_gnt, mem_bus_out, mem_read_write, write_commit}),
                   64'({3'b000, 10'h303, 1'b0, 1'b0}));
      tick();
      mid(); check("arb_c2", 64'({st_gnt, ld_gnt, fetch_gnt, mem_bus_out, mem_read_write, write_commit}),
                   64'({3'b010, 10'h03F, 1'b0, 1'b1}));
      tick(); ld_req = 1'b0;
      mid(); check("arb_c3", 64'({st_gnt, ld_gnt, fetch_gnt, mem_bus_out, mem_read_write, st_done}),
                   64'({3'b001, 10'h202, 1'b1, 1'b1}));
      tick(); fetch_req = 1'b0;
      mid(); check("arb_c4", 64'({st_gnt, ld_gnt, fetch_gnt, mem_bus_out, mem_read_write}),
                   64'({3'b000, 10'h101, 1'b1}));
      tick();

      // Starvation guard: loads and fetch held, fetch forced in after every 4 loads.
      do_reset();
      ld_req = 1'b1; ld_addr = 10'h0A0;
      fetch_req = 1'b1; fetch_addr = 10'h0F0;
      for (int i = 0; i < 12; i++) begin
         mid();
         check($sformatf("starve_c%0d", i), 64'({st_gnt, ld_gnt, fetch_gnt}),
               64'((i % 5 == 4) ? 3'b001 : 3'b010));
         tick();
      end
      ld_req = 1'b0; fetch_req = 1'b0;

      // Halt with fetch pending: fetch first, then terminal HALT, then reset back to IDLE.
      do_reset();
      fetch_req = 1'b1; fetch_addr = 10'h040; halt_req = 1'b1;
      mid(); check("halt_c0_gnt", 64'({st_gnt, ld_gnt, fetch_gnt}), 64'(3'b001));
      tick(); fetch_req = 1'b0; mem_result = 12'h777;
      mid(); check("halt_c1", 64'({st_gnt, ld_gnt, fetch_gnt, mem_bus_out, halted}),
                   64'({3'b000, 10'h040, 1'b0}));
      tick();
      fetch_req = 1'b1; ld_req = 1'b1; st_req = 1'b1;
      mid(); check("halt_fetch_done", 64'({fetch_valid, fetch_data}), 64'({1'b1, 12'h777}));
      for (int i = 0; i < 20; i++) begin
         check($sformatf("halt_hold_%0d", i),
               64'({st_gnt, ld_gnt, fetch_gnt, mem_bus_out, mem_read_write, write_commit, halted}),
               64'({3'b000, 10'h000, 1'b1, 1'b1, 1'b1}));
         tick();
         mid();
      end
      tick();
      apply('0);
      rst = 1'b1;
      tick(); rst = 1'b0;
      mid(); check("halt_rst_idle", 64'({mem_bus_out, mem_read_write, write_commit, halted}),
                   64'({10'h000, 1'b1, 1'b0, 1'b0}));
      tick();

      // Reset during ST_ADDR aborts the store: no data phase and no st_done.
      do_reset();
      st_req = 1'b1; st_addr = 10'h2AA; st_data = 6'h15; st_upper = 1'b0;
      mid(); check("abort_gnt", 64'(st_gnt), 64'(1'b1));
      tick(); st_req = 1'b0; rst = 1'b1;
      mid(); check("abort_staddr", 64'({mem_bus_out, mem_read_write, write_commit}),
                   64'({10'h2AA, 1'b0, 1'b0}));
      tick(); rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         mid(); check($sformatf("abort_after_%0d", i),
                      64'({mem_bus_out, mem_read_write, write_commit, st_done}),
                      64'({10'h000, 1'b1, 1'b0, 1'b0}));
         tick();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
